// File: rtl/ascon_block_packer.sv
// ---------------------------------------------------------------------------
// ascon_block_packer
//
// Assembles a byte stream (associated data or plaintext) into 128-bit ASCON
// rate blocks, applies 0x01/zero padding and presents each block to the
// AEAD control FSM until it is consumed.
//
// State table:
//   state    | meaning
//   FILL     | collecting bytes into the buffer, byte_ready_o=1
//   HOLD     | block presented, waiting for block_ack_i
//   HOLD_PAD | extra pad-only block presented after a full last block
//
// Ports:
//   clock_i        system clock, rising edge
//   reset_i        synchronous reset, active-high
//   byte_i         input data byte
//   byte_valid_i   byte_i valid this cycle
//   byte_last_i    byte_i is the final byte of its segment
//   flush_i        close the current segment without a byte
//   byte_ready_o   packer accepts a byte or flush this cycle
//   block_o        padded block, byte k at bits [8k+7:8k]
//   block_valid_o  block_o is valid and held
//   block_last_o   block_o is the final padded block of its segment
//   block_nbytes_o real data bytes in block_o (0..16)
//   block_ack_i    one-cycle consume pulse from the FSM
// ---------------------------------------------------------------------------
module ascon_block_packer #(
    parameter int RATE_BYTES = 16,
    parameter int IDX_W      = 4
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [7:0]              byte_i,
    input  logic                    byte_valid_i,
    input  logic                    byte_last_i,
    input  logic                    flush_i,
    output logic                    byte_ready_o,
    output logic [8*RATE_BYTES-1:0] block_o,
    output logic                    block_valid_o,
    output logic                    block_last_o,
    output logic [4:0]              block_nbytes_o,
    input  logic                    block_ack_i
);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        HOLD     = 2'd1,
        HOLD_PAD = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_BYTES - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [8*RATE_BYTES-1:0] buf_q, buf_d;
    logic                    pend_pad_q, pend_pad_d;
    logic                    last_q, last_d;
    logic [4:0]              nbytes_q, nbytes_d;
    logic [IDX_W-1:0]        idx_inc;

    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        pend_pad_d = pend_pad_q;
        last_d     = last_q;
        nbytes_d   = nbytes_q;

        case (state_q)
            FILL: begin
                // A valid byte always wins over a simultaneous flush.
                if (byte_valid_i) begin
                    buf_d[{idx_q, 3'b000} +: 8] = byte_i;
                    if (idx_q == LAST_IDX) begin
                        // Full block; a last byte here defers its padding to
                        // a separate pad-only block.
                        state_d    = HOLD;
                        nbytes_d   = 5'(RATE_BYTES);
                        last_d     = 1'b0;
                        pend_pad_d = byte_last_i;
                    end else if (byte_last_i) begin
                        buf_d[{idx_inc, 3'b000} +: 8] = 8'h01;
                        state_d  = HOLD;
                        nbytes_d = 5'(idx_q) + 5'd1;
                        last_d   = 1'b1;
                    end else begin
                        idx_d = idx_inc;
                    end
                end else if (flush_i) begin
                    buf_d[{idx_q, 3'b000} +: 8] = 8'h01;
                    state_d  = HOLD;
                    nbytes_d = 5'(idx_q);
                    last_d   = 1'b1;
                end
            end

            HOLD: begin
                if (block_ack_i) begin
                    if (pend_pad_q) begin
                        buf_d      = '0;
                        buf_d[7:0] = 8'h01;
                        nbytes_d   = 5'd0;
                        last_d     = 1'b1;
                        pend_pad_d = 1'b0;
                        state_d    = HOLD_PAD;
                    end else begin
                        buf_d    = '0;
                        idx_d    = '0;
                        last_d   = 1'b0;
                        nbytes_d = 5'd0;
                        state_d  = FILL;
                    end
                end
            end

            HOLD_PAD: begin
                if (block_ack_i) begin
                    buf_d    = '0;
                    idx_d    = '0;
                    last_d   = 1'b0;
                    nbytes_d = 5'd0;
                    state_d  = FILL;
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= FILL;
            idx_q      <= '0;
            buf_q      <= '0;
            pend_pad_q <= 1'b0;
            last_q     <= 1'b0;
            nbytes_q   <= 5'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            pend_pad_q <= pend_pad_d;
            last_q     <= last_d;
            nbytes_q   <= nbytes_d;
        end
    end

    // Handshake outputs are pure decodes of the state register.
    assign byte_ready_o   = (state_q == FILL);
    assign block_valid_o  = (state_q == HOLD) || (state_q == HOLD_PAD);
    assign block_o        = buf_q;
    assign block_last_o   = last_q;
    assign block_nbytes_o = nbytes_q;

endmodule

// File: tb/tb_ascon_block_packer.sv
module tb_ascon_block_packer;

    logic         clock_i = 1'b0;
    logic         reset_i;
    logic [7:0]   byte_i;
    logic         byte_valid_i;
    logic         byte_last_i;
    logic         flush_i;
    logic         byte_ready_o;
    logic [127:0] block_o;
    logic         block_valid_o;
    logic         block_last_o;
    logic [4:0]   block_nbytes_o;
    logic         block_ack_i;

    ascon_block_packer dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .byte_i         (byte_i),
        .byte_valid_i   (byte_valid_i),
        .byte_last_i    (byte_last_i),
        .flush_i        (flush_i),
        .byte_ready_o   (byte_ready_o),
        .block_o        (block_o),
        .block_valid_o  (block_valid_o),
        .block_last_o   (block_last_o),
        .block_nbytes_o (block_nbytes_o),
        .block_ack_i    (block_ack_i)
    );

    always #5 clock_i = ~clock_i;

    typedef struct packed {
        logic [127:0] blk;
        logic         last;
        logic [4:0]   n;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] part;
    int           part_n;
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        part   = '0;
        part_n = 0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (byte_ready_o !== 1'b1 && k < 50) begin
            @(negedge clock_i);
            k++;
        end
        if (k == 50) check("ready_timeout", 0, 1);
    endtask

    // Drives one byte (optionally with flush_i) and updates the reference model.
    task automatic send_byte(input logic [7:0] b, input bit last, input bit with_flush = 0);
        wait_ready();
        byte_i       = b;
        byte_valid_i = 1'b1;
        byte_last_i  = last;
        flush_i      = with_flush;
        @(posedge clock_i);
        @(negedge clock_i);
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        flush_i      = 1'b0;
        part[part_n*8 +: 8] = b;
        part_n++;
        if (part_n == 16) begin
            sb.push_back('{blk: part, last: 1'b0, n: 5'd16});
            if (last) sb.push_back('{blk: 128'h1, last: 1'b1, n: 5'd0});
            model_reset();
        end else if (last) begin
            part[part_n*8 +: 8] = 8'h01;
            sb.push_back('{blk: part, last: 1'b1, n: 5'(part_n)});
            model_reset();
        end
    endtask

    task automatic send_run(input logic [7:0] base, input int n, input bit last_on_end);
        for (int i = 0; i < n; i++)
            send_byte(base + 8'(i), last_on_end && (i == n - 1));
    endtask

    task automatic do_flush();
        wait_ready();
        flush_i = 1'b1;
        @(posedge clock_i);
        @(negedge clock_i);
        flush_i = 1'b0;
        part[part_n*8 +: 8] = 8'h01;
        sb.push_back('{blk: part, last: 1'b1, n: 5'(part_n)});
        model_reset();
    endtask

    // Waits for a block, compares it to the scoreboard head and acks it.
    task automatic consume(input string tag, input bit valid_after);
        exp_t e;
        int   k = 0;
        while (block_valid_o !== 1'b1 && k < 50) begin
            @(negedge clock_i);
            k++;
        end
        if (k == 50) begin
            check({tag, "_valid_timeout"}, 0, 1);
            return;
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_block"},  block_o, e.blk);
        check({tag, "_last"},   128'(block_last_o), 128'(e.last));
        check({tag, "_nbytes"}, 128'(block_nbytes_o), 128'(e.n));
        check({tag, "_ready_in_hold"}, 128'(byte_ready_o), 0);
        block_ack_i = 1'b1;
        @(posedge clock_i);
        @(negedge clock_i);
        block_ack_i = 1'b0;
        check({tag, "_valid_after_ack"}, 128'(block_valid_o), 128'(valid_after));
        check({tag, "_ready_after_ack"}, 128'(byte_ready_o), 128'(!valid_after));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] held;
        reset_i = 1'b1; byte_i = '0; byte_valid_i = 0; byte_last_i = 0;
        flush_i = 0; block_ack_i = 0;
        model_reset();
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b0;
        check("rst_ready",  128'(byte_ready_o), 1);
        check("rst_valid",  128'(block_valid_o), 0);
        check("rst_last",   128'(block_last_o), 0);
        check("rst_nbytes", 128'(block_nbytes_o), 0);
        check("rst_block",  block_o, 0);

        // 1: full block, no last
        send_run(8'h00, 16, 0);
        check("t1_latency", 128'(block_valid_o), 1);
        check("t1_const", block_o, 128'h0F0E0D0C0B0A09080706050403020100);
        consume("t1", 0);

        // 2: short last segment
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 1);
        check("t2_const", block_o, 128'h01CCBBAA);
        consume("t2", 0);

        // 3: full last block followed by pad-only block
        send_run(8'h10, 16, 1);
        consume("t3_full", 1);
        check("t3_pad_const", block_o, 128'h1);
        consume("t3_pad", 0);

        // 4: flush at idx 0, flush ignored alongside a byte, flush at idx 5
        do_flush();
        consume("t4_flush0", 0);
        send_byte(8'h55, 0, 1);
        check("t4_no_block", 128'(block_valid_o), 0);
        check("t4_still_ready", 128'(byte_ready_o), 1);
        send_byte(8'h66, 1);
        check("t4_const", block_o, 128'h016655);
        consume("t4_kept", 0);
        send_run(8'h30, 5, 0);
        do_flush();
        consume("t4_flush5", 0);
        send_run(8'h40, 15, 1);
        consume("t4_last15", 0);

        // 5: hold without ack while bytes are offered, then stray ack in FILL
        send_run(8'h50, 16, 0);
        held = block_o;
        byte_valid_i = 1'b1; byte_i = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock_i);
            @(negedge clock_i);
            check("t5_hold_ready", 128'(byte_ready_o), 0);
            check("t5_hold_block", block_o, sb[0].blk);
        end
        byte_valid_i = 1'b0;
        check("t5_held_equal", block_o, held);
        consume("t5", 0);
        send_run(8'h60, 3, 0);
        block_ack_i = 1'b1;
        @(posedge clock_i);
        @(negedge clock_i);
        block_ack_i = 1'b0;
        check("t5_stray_ack_valid", 128'(block_valid_o), 0);
        check("t5_stray_ack_ready", 128'(byte_ready_o), 1);
        send_run(8'h63, 13, 0);
        consume("t5_after_stray", 0);

        // 6: reset mid-block discards partial data
        send_run(8'h70, 7, 0);
        reset_i = 1'b1;
        @(posedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b0;
        model_reset();
        check("t6_ready", 128'(byte_ready_o), 1);
        check("t6_valid", 128'(block_valid_o), 0);
        check("t6_block", block_o, 0);
        send_run(8'h80, 16, 0);
        consume("t6", 0);

        check("sb_drained", 128'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
